// File: rtl/cmos_dvp_capture_if.sv
// Pixel stream from one camera capture front end to the dual-camera merge stage.
// Master drives the frame-gated vsync/href/de/data; slave observes them.
interface cmos_dvp_capture_if;
  logic        pixel_vsync;
  logic        pixel_href;
  logic        pixel_de;
  logic [15:0] pixel_data;

  modport master (output pixel_vsync, pixel_href, pixel_de, pixel_data);
  modport slave  (input  pixel_vsync, pixel_href, pixel_de, pixel_data);
endinterface

// File: rtl/cmos_dvp_capture.sv
// OV5640 DVP capture: pairs sensor bytes into RGB565 words, 2-cycle pin-to-output latency, no backpressure.
// Skips SKIP_FRAMES frames after reset. Optional line/frame stats under `define CMOS_CAP_STATS_EN.
module cmos_dvp_capture #(
  parameter int SKIP_FRAMES = 10,
  parameter int H_PIXELS    = 640,
  parameter int CNT_W       = 12
) (
  input  logic                cmos_pclk,
  input  logic                sys_rst_n,
  input  logic                cmos_vsync,
  input  logic                cmos_href,
  input  logic [7:0]          cmos_db,
  output logic                frame_ready,
  cmos_dvp_capture_if.master  pix
`ifdef CMOS_CAP_STATS_EN
  ,
  output logic [CNT_W-1:0]    meas_pix,
  output logic [CNT_W-1:0]    meas_lines,
  output logic                line_err
`endif
);

  localparam logic [CNT_W-1:0] SKIP_N         = CNT_W'(SKIP_FRAMES);
  localparam bit               READY_AT_RESET = (SKIP_FRAMES == 0);

  logic              vs_q, hs_q, vs_prev_q, act_prev_q;
  logic [7:0]        db_q;
  logic              vs_d, hs_d, vs_prev_d, act_prev_d;
  logic [7:0]        db_d;
  logic [CNT_W-1:0]  skip_cnt_q, skip_cnt_d;
  logic              frame_ready_q, frame_ready_d;
  logic              byte_sel_q, byte_sel_d;
  logic [7:0]        hi_byte_q, hi_byte_d;
  logic              pixel_vsync_q, pixel_vsync_d;
  logic              pixel_href_q, pixel_href_d;
  logic              pixel_de_q, pixel_de_d;
  logic [15:0]       pixel_data_q, pixel_data_d;
  logic              frame_start, act, line_end, pair_done;

  always_comb begin
    vs_d       = cmos_vsync;
    hs_d       = cmos_href;
    db_d       = cmos_db;
    vs_prev_d  = vs_q;
    frame_start = vs_q & ~vs_prev_q;
    act        = hs_q & ~vs_q;
    act_prev_d = act;
    line_end   = act_prev_q & ~act;
    pair_done  = act & byte_sel_q;

    // Counter saturates after SKIP_FRAMES starts; the next start opens the gate so the first delivered frame is whole.
    skip_cnt_d    = skip_cnt_q;
    frame_ready_d = frame_ready_q;
    if (skip_cnt_q == SKIP_N) begin
      if (frame_start || READY_AT_RESET) frame_ready_d = 1'b1;
    end else if (frame_start) begin
      skip_cnt_d = skip_cnt_q + 1'b1;
    end

    byte_sel_d   = 1'b0;
    hi_byte_d    = hi_byte_q;
    pixel_data_d = pixel_data_q;
    pixel_de_d   = 1'b0;
    if (act) begin
      if (!byte_sel_q) begin
        hi_byte_d  = db_q;
        byte_sel_d = 1'b1;
      end else if (frame_ready_d) begin
        pixel_data_d = {hi_byte_q, db_q};
        pixel_de_d   = 1'b1;
      end
    end

    pixel_vsync_d = frame_ready_d & vs_q;
    pixel_href_d  = frame_ready_d & act;
  end

  always_ff @(posedge cmos_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_q          <= 1'b0;
      hs_q          <= 1'b0;
      db_q          <= 8'h00;
      vs_prev_q     <= 1'b0;
      act_prev_q    <= 1'b0;
      skip_cnt_q    <= '0;
      frame_ready_q <= 1'b0;
      byte_sel_q    <= 1'b0;
      hi_byte_q     <= 8'h00;
      pixel_vsync_q <= 1'b0;
      pixel_href_q  <= 1'b0;
      pixel_de_q    <= 1'b0;
      pixel_data_q  <= 16'h0000;
    end else begin
      vs_q          <= vs_d;
      hs_q          <= hs_d;
      db_q          <= db_d;
      vs_prev_q     <= vs_prev_d;
      act_prev_q    <= act_prev_d;
      skip_cnt_q    <= skip_cnt_d;
      frame_ready_q <= frame_ready_d;
      byte_sel_q    <= byte_sel_d;
      hi_byte_q     <= hi_byte_d;
      pixel_vsync_q <= pixel_vsync_d;
      pixel_href_q  <= pixel_href_d;
      pixel_de_q    <= pixel_de_d;
      pixel_data_q  <= pixel_data_d;
    end
  end

  assign frame_ready     = frame_ready_q;
  assign pix.pixel_vsync = pixel_vsync_q;
  assign pix.pixel_href  = pixel_href_q;
  assign pix.pixel_de    = pixel_de_q;
  assign pix.pixel_data  = pixel_data_q;

`ifdef CMOS_CAP_STATS_EN
  localparam logic [CNT_W-1:0] H_N = CNT_W'(H_PIXELS);

  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0] meas_pix_q, meas_pix_d;
  logic [CNT_W-1:0] meas_lines_q, meas_lines_d;
  logic             line_err_q, line_err_d;

  // Stats count completed pairs regardless of frame_ready so they are valid during settling.
  always_comb begin
    pix_cnt_d    = pix_cnt_q + {{(CNT_W-1){1'b0}}, pair_done};
    line_cnt_d   = line_cnt_q + {{(CNT_W-1){1'b0}}, line_end};
    meas_pix_d   = meas_pix_q;
    meas_lines_d = meas_lines_q;
    line_err_d   = line_err_q;
    if (line_end) begin
      meas_pix_d = pix_cnt_q;
      pix_cnt_d  = '0;
      if (byte_sel_q || (pix_cnt_q != H_N)) line_err_d = 1'b1;
    end
    if (frame_start) begin
      meas_lines_d = line_cnt_d;
      line_cnt_d   = '0;
      line_err_d   = 1'b0;
    end
  end

  always_ff @(posedge cmos_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      meas_pix_q   <= '0;
      meas_lines_q <= '0;
      line_err_q   <= 1'b0;
    end else begin
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      meas_pix_q   <= meas_pix_d;
      meas_lines_q <= meas_lines_d;
      line_err_q   <= line_err_d;
    end
  end

  assign meas_pix   = meas_pix_q;
  assign meas_lines = meas_lines_q;
  assign line_err   = line_err_q;
`endif

endmodule

// File: tb/tb_cmos_dvp_capture.sv
// Directed bench for cmos_dvp_capture with SKIP_FRAMES=2 and 8-pixel lines.
module tb_cmos_dvp_capture;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic [7:0] db = 8'h00;
  logic       frame_ready;
`ifdef CMOS_CAP_STATS_EN
  logic [11:0] meas_pix, meas_lines;
  logic        line_err;
`endif

  int checks = 0;
  int errors = 0;
  int de_total = 0;
  int viol = 0;
  logic        prev_de = 1'b0;
  logic [15:0] dat_hist [0:255];

  cmos_dvp_capture_if pix ();

  cmos_dvp_capture #(.SKIP_FRAMES(2), .H_PIXELS(8), .CNT_W(12)) dut (
    .cmos_pclk   (clk),
    .sys_rst_n   (rst_n),
    .cmos_vsync  (vsync),
    .cmos_href   (href),
    .cmos_db     (db),
    .frame_ready (frame_ready),
    .pix         (pix.master)
`ifdef CMOS_CAP_STATS_EN
    ,
    .meas_pix    (meas_pix),
    .meas_lines  (meas_lines),
    .line_err    (line_err)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pix.pixel_de) begin
      dat_hist[de_total[7:0]] = pix.pixel_data;
      de_total = de_total + 1;
      if (prev_de) viol = viol + 1;
      if (!pix.pixel_href) viol = viol + 1;
    end
    prev_de = pix.pixel_de;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_vsync();
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_lines(input int n, input int len, input logic [7:0] base);
    for (int l = 0; l < n; l++) begin
      for (int b = 0; b < len; b++) begin
        href = 1'b1;
        db = 8'(base + b);
        tick();
      end
      href = 1'b0;
      repeat (4) tick();
    end
  endtask

  task automatic check_de(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: de count %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({frame_ready, pix.pixel_vsync, pix.pixel_href, pix.pixel_de} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000",
               {frame_ready, pix.pixel_vsync, pix.pixel_href, pix.pixel_de});
    end
    checks++;
    if (pix.pixel_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0000", pix.pixel_data);
    end
`ifdef CMOS_CAP_STATS_EN
    checks++;
    if ({meas_pix, meas_lines, line_err} !== 25'd0) begin
      errors++;
      $display("FAIL reset_stats: pix %0d lines %0d err %b expected 0", meas_pix, meas_lines, line_err);
    end
`endif
  endtask

  task automatic test_skip();
    int s;
    for (int f = 0; f < 2; f++) begin
      s = de_total;
      send_vsync();
      send_lines(4, 16, 8'h00);
      check_de("skip_frame", de_total - s, 0);
    end
    checks++;
    if (frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_early: got %b expected 0", frame_ready);
    end
    s = de_total;
    vsync = 1'b1;
    tick();
    checks++;
    if (frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_at_sample: got %b expected 0", frame_ready);
    end
    tick();
    checks++;
    if (frame_ready !== 1'b1 || pix.pixel_vsync !== 1'b1) begin
      errors++;
      $display("FAIL ready_rise: ready %b vsync %b expected 1 1", frame_ready, pix.pixel_vsync);
    end
    tick();
    vsync = 1'b0;
    repeat (3) tick();
    send_lines(4, 16, 8'h00);
    check_de("frame2", de_total - s, 32);
    s = de_total;
    send_vsync();
    send_lines(4, 16, 8'h00);
    check_de("frame3", de_total - s, 32);
  endtask

  task automatic test_pair();
    href = 1'b1;
    db = 8'hF8;
    tick();
    checks++;
    if (pix.pixel_href !== 1'b0) begin
      errors++;
      $display("FAIL pair_href_early: got %b expected 0", pix.pixel_href);
    end
    db = 8'h1F;
    tick();
    checks++;
    if (pix.pixel_href !== 1'b1 || pix.pixel_de !== 1'b0) begin
      errors++;
      $display("FAIL pair_stage1: href %b de %b expected 1 0", pix.pixel_href, pix.pixel_de);
    end
    href = 1'b0;
    tick();
    checks++;
    if (pix.pixel_de !== 1'b1 || pix.pixel_data !== 16'hF81F || pix.pixel_href !== 1'b1) begin
      errors++;
      $display("FAIL pair_word: de %b data %h href %b expected 1 f81f 1",
               pix.pixel_de, pix.pixel_data, pix.pixel_href);
    end
    tick();
    checks++;
    if (pix.pixel_de !== 1'b0 || pix.pixel_href !== 1'b0 || pix.pixel_data !== 16'hF81F) begin
      errors++;
      $display("FAIL pair_hold: de %b href %b data %h expected 0 0 f81f",
               pix.pixel_de, pix.pixel_href, pix.pixel_data);
    end
    repeat (3) tick();
  endtask

  task automatic test_odd_line();
    int s;
    send_vsync();
    s = de_total;
    send_lines(1, 17, 8'h10);
    check_de("odd_line", de_total - s, 8);
    checks++;
    if (dat_hist[8'(s + 7)] !== 16'h1E1F) begin
      errors++;
      $display("FAIL odd_last_word: got %h expected 1e1f", dat_hist[8'(s + 7)]);
    end
`ifdef CMOS_CAP_STATS_EN
    checks++;
    if (meas_pix !== 12'd8 || line_err !== 1'b1) begin
      errors++;
      $display("FAIL odd_stats: meas_pix %0d err %b expected 8 1", meas_pix, line_err);
    end
`endif
    s = de_total;
    send_lines(1, 8, 8'hA0);
    check_de("after_odd", de_total - s, 4);
    checks++;
    if (dat_hist[8'(s)] !== 16'hA0A1) begin
      errors++;
      $display("FAIL after_odd_first: got %h expected a0a1", dat_hist[8'(s)]);
    end
`ifdef CMOS_CAP_STATS_EN
    send_vsync();
    checks++;
    if (line_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b expected 0", line_err);
    end
`endif
  endtask

  task automatic test_vsync_href();
    int  s;
    bit  href_seen;
    s = de_total;
    href_seen = 1'b0;
    vsync = 1'b1;
    tick();
    for (int b = 0; b < 4; b++) begin
      href = 1'b1;
      db = 8'(8'h55 + b);
      tick();
      if (pix.pixel_href !== 1'b0) href_seen = 1'b1;
    end
    href = 1'b0;
    repeat (2) tick();
    if (pix.pixel_href !== 1'b0) href_seen = 1'b1;
    vsync = 1'b0;
    repeat (3) tick();
    checks++;
    if (href_seen) begin
      errors++;
      $display("FAIL vs_href: pixel_href went 1, expected 0");
    end
    check_de("vs_href_de", de_total - s, 0);
    s = de_total;
    href = 1'b1;
    db = 8'h12;
    tick();
    db = 8'h34;
    tick();
    href = 1'b0;
    repeat (4) tick();
    check_de("vs_href_next", de_total - s, 1);
    checks++;
    if (dat_hist[8'(s)] !== 16'h1234) begin
      errors++;
      $display("FAIL vs_href_word: got %h expected 1234", dat_hist[8'(s)]);
    end
  endtask

`ifdef CMOS_CAP_STATS_EN
  task automatic test_stats();
    send_vsync();
    send_lines(6, 16, 8'h40);
    send_vsync();
    checks++;
    if (meas_lines !== 12'd6 || meas_pix !== 12'd8 || line_err !== 1'b0) begin
      errors++;
      $display("FAIL stats_frame: lines %0d pix %0d err %b expected 6 8 0", meas_lines, meas_pix, line_err);
    end
  endtask
`endif

  task automatic test_async_reset();
    int s;
    send_vsync();
    href = 1'b1;
    for (int b = 0; b < 5; b++) begin
      db = 8'(8'h80 + b);
      tick();
    end
    checks++;
    if (pix.pixel_href !== 1'b1 || frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: href %b ready %b expected 1 1", pix.pixel_href, frame_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({frame_ready, pix.pixel_vsync, pix.pixel_href, pix.pixel_de} !== 4'b0000 ||
        pix.pixel_data !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset: ctrl %b data %h expected 0000 0000",
               {frame_ready, pix.pixel_vsync, pix.pixel_href, pix.pixel_de}, pix.pixel_data);
    end
    href = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int f = 0; f < 2; f++) begin
      s = de_total;
      send_vsync();
      send_lines(4, 16, 8'h00);
      check_de("reskip_frame", de_total - s, 0);
    end
    checks++;
    if (frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL reskip_ready: got %b expected 0", frame_ready);
    end
    s = de_total;
    send_vsync();
    send_lines(4, 16, 8'h00);
    check_de("reskip_deliver", de_total - s, 32);
    checks++;
    if (frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL reskip_ready_late: got %b expected 1", frame_ready);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL de_protocol: %0d violations, expected 0", viol);
    end
  endtask

  initial begin
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_skip();
    test_pair();
    test_odd_line();
    test_vsync_href();
`ifdef CMOS_CAP_STATS_EN
    test_stats();
`endif
    test_async_reset();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
